// File: rtl/program_loader.sv
// program_loader
//   Receives a byte-serial program (high byte of each word first), packs it
//   into a MEM_DEPTH x DATA_WIDTH word memory, then releases the core to run.
//   The core shares the same memory through a combinational read port and a
//   write port that is only honoured once the program is loaded.
//
// Ports
//   clock, reset          sole clock, synchronous active-high reset
//   load_valid/ready      byte handshake; a byte moves when both are high
//   load_byte, load_last  program byte and end-of-program marker
//   core_addr             core address (read always, write in RUN/DONE)
//   core_write(_data)     core write strobe and data
//   core_read_data        mem[core_addr], zero-cycle latency
//   core_halted           core has executed HALT
//   start_execution       registered, high exactly while running
//   words_loaded          words written by the loader (0..MEM_DEPTH)
//   done, load_error      terminal status flags
//
// state     | meaning
// ----------+----------------------------------------------------------
// LOAD_HI   | waiting for the high byte of the next word
// LOAD_LO   | high byte latched, waiting for the low byte
// RUN       | program loaded, core executing
// DONE      | core halted; held until reset
// ERROR     | odd byte count or overflow; held until reset
module program_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int MEM_DEPTH  = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [7:0]            load_byte,
   input  logic                  load_last,
   input  logic [ADDR_WIDTH-1:0] core_addr,
   input  logic                  core_write,
   input  logic [DATA_WIDTH-1:0] core_write_data,
   output logic [DATA_WIDTH-1:0] core_read_data,
   input  logic                  core_halted,
   output logic                  start_execution,
   output logic [ADDR_WIDTH:0]   words_loaded,
   output logic                  done,
   output logic                  load_error
);

   typedef enum logic [2:0] {
      S_LOAD_HI = 3'd0,
      S_LOAD_LO = 3'd1,
      S_RUN     = 3'd2,
      S_DONE    = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
   logic [7:0]             hi_q, hi_d;
   logic                   start_q, start_d;
   logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

   logic                   mem_we;
   logic [ADDR_WIDTH-1:0]  mem_waddr;
   logic [DATA_WIDTH-1:0]  mem_wdata;
   logic                   accept;

   assign accept = load_valid & load_ready;

   // state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_LOAD_HI;
         wr_ptr_q <= '0;
         hi_q     <= '0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         hi_q     <= hi_d;
         start_q  <= start_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // next-state and memory write selection
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      hi_d      = hi_q;
      mem_we    = 1'b0;
      mem_waddr = wr_ptr_q[ADDR_WIDTH-1:0];
      mem_wdata = DATA_WIDTH'({hi_q, load_byte});
      case (state_q)
         S_LOAD_HI: begin
            if (accept) begin
               // a word can never start on the final byte, and a full
               // memory cannot take another word
               if ((wr_ptr_q == DEPTH_W) || load_last) begin
                  state_d = S_ERROR;
               end else begin
                  hi_d    = load_byte;
                  state_d = S_LOAD_LO;
               end
            end
         end
         S_LOAD_LO: begin
            if (accept) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + ONE_W;
               state_d  = load_last ? S_RUN : S_LOAD_HI;
            end
         end
         S_RUN: begin
            mem_we    = core_write;
            mem_waddr = core_addr;
            mem_wdata = core_write_data;
            if (core_halted) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            mem_we    = core_write;
            mem_waddr = core_addr;
            mem_wdata = core_write_data;
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d = S_ERROR;
         end
      endcase
      start_d = (state_d == S_RUN);
   end

   // outputs
   always_comb begin
      load_ready = (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO);
      done       = (state_q == S_DONE);
      load_error = (state_q == S_ERROR);
   end

   assign start_execution = start_q;
   assign words_loaded    = wr_ptr_q;
   assign core_read_data  = mem_q[core_addr];

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_valid;
   logic        load_ready;
   logic [7:0]  load_byte;
   logic        load_last;
   logic [4:0]  core_addr;
   logic        core_write;
   logic [15:0] core_write_data;
   logic [15:0] core_read_data;
   logic        core_halted;
   logic        start_execution;
   logic [5:0]  words_loaded;
   logic        done;
   logic        load_error;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   program_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .MEM_DEPTH(32)) dut (
      .clock(clock), .reset(reset),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_byte(load_byte), .load_last(load_last),
      .core_addr(core_addr), .core_write(core_write),
      .core_write_data(core_write_data), .core_read_data(core_read_data),
      .core_halted(core_halted), .start_execution(start_execution),
      .words_loaded(words_loaded), .done(done), .load_error(load_error)
   );

   // Reference model: the program is a byte stream; words are byte pairs.
   bit [15:0] m_mem [32];
   int        m_nbytes;
   bit [7:0]  m_hi;
   bit        m_run, m_done, m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit v, input bit [7:0] b, input bit l,
                             input bit [4:0] ca, input bit cw, input bit [15:0] cwd,
                             input bit ch);
      if (r) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         m_nbytes = 0; m_hi = 0; m_run = 0; m_done = 0; m_err = 0;
         return;
      end
      if (m_err) return;
      if (m_done) begin
         if (cw) m_mem[ca] = cwd;
         return;
      end
      if (m_run) begin
         if (cw) m_mem[ca] = cwd;
         if (ch) begin m_run = 0; m_done = 1; end
         return;
      end
      if (!v) return;
      if (m_nbytes % 2 == 0) begin
         if (m_nbytes / 2 == 32 || l) m_err = 1;
         else begin m_hi = b; m_nbytes++; end
      end else begin
         m_mem[m_nbytes / 2] = {m_hi, b};
         m_nbytes++;
         if (l) m_run = 1;
      end
   endtask

   task automatic check_outs();
      chk("load_ready", load_ready, !(m_run || m_done || m_err));
      chk("start_execution", start_execution, m_run);
      chk("done", done, m_done);
      chk("load_error", load_error, m_err);
      chk("words_loaded", words_loaded, m_nbytes / 2);
      chk("core_read_data", core_read_data, m_mem[core_addr]);
   endtask

   task automatic cyc();
      bit r, v, l, cw, ch;
      bit [7:0] b;
      bit [4:0] ca;
      bit [15:0] cwd;
      r = reset; v = load_valid; b = load_byte; l = load_last;
      ca = core_addr; cw = core_write; cwd = core_write_data; ch = core_halted;
      @(posedge clock); #1;
      model_edge(r, v, b, l, ca, cw, cwd, ch);
      check_outs();
   endtask

   task automatic idle();
      reset = 0; load_valid = 0; load_byte = 8'h00; load_last = 0;
      core_write = 0; core_write_data = 16'h0; core_halted = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      cyc(); cyc();
      reset = 0;
   endtask

   task automatic send(input bit [7:0] b, input bit l);
      load_valid = 1; load_byte = b; load_last = l;
      cyc();
      load_valid = 0; load_last = 0;
   endtask

   // inputs stay idle, so the clock edges crossed here change nothing
   task automatic sweep_mem(input string name);
      idle();
      for (int a = 0; a < 32; a++) begin
         core_addr = 5'(a);
         #1;
         chk(name, core_read_data, m_mem[a]);
      end
      core_addr = 0;
   endtask

   task automatic read_at(input string name, input bit [4:0] a, input bit [15:0] exp);
      core_addr = a; #1;
      chk(name, core_read_data, exp);
   endtask

   typedef struct {
      bit       v;
      bit [7:0] b;
      bit       l;
      bit       e_ready;
      bit       e_start;
      int       e_words;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{1, 8'h88, 0, 1, 0, 0};
      vecs[1] = '{0, 8'h55, 1, 1, 0, 0};
      vecs[2] = '{1, 8'h05, 0, 1, 0, 1};
      vecs[3] = '{1, 8'hF8, 0, 1, 0, 1};
      vecs[4] = '{1, 8'h00, 1, 0, 1, 2};
      vecs[5] = '{1, 8'h77, 1, 0, 1, 2};

      core_addr = 0;
      do_reset();
      chk("reset_ready", load_ready, 1);
      chk("reset_words", words_loaded, 0);
      sweep_mem("reset_mem");

      // basic load, with a gap cycle carrying load_last that must be ignored
      for (int i = 0; i < 6; i++) begin
         load_valid = vecs[i].v; load_byte = vecs[i].b; load_last = vecs[i].l;
         cyc();
         chk("vec_ready", load_ready, vecs[i].e_ready);
         chk("vec_start", start_execution, vecs[i].e_start);
         chk("vec_words", words_loaded, vecs[i].e_words);
      end
      idle();
      read_at("mem0", 0, 16'h8805);
      read_at("mem1", 1, 16'hF800);

      // core write in RUN, then halt; DONE keeps accepting core writes
      core_addr = 3; core_write = 1; core_write_data = 16'hBEEF;
      cyc();
      core_write = 0;
      read_at("mem3_run", 3, 16'hBEEF);
      core_halted = 1;
      cyc();
      core_halted = 0;
      chk("halt_start", start_execution, 0);
      chk("halt_done", done, 1);
      core_addr = 4; core_write = 1; core_write_data = 16'h1234;
      cyc();
      idle();
      read_at("mem4_done", 4, 16'h1234);
      send(8'h11, 0); send(8'h22, 1);
      chk("done_hold", done, 1);
      sweep_mem("after_done");

      // odd byte count
      do_reset();
      send(8'hAB, 1);
      chk("odd_err", load_error, 1);
      chk("odd_ready", load_ready, 0);
      chk("odd_words", words_loaded, 0);
      send(8'h01, 0); send(8'h02, 1);
      chk("odd_hold", load_error, 1);
      core_write = 1; core_write_data = 16'hDEAD; core_addr = 7;
      cyc();
      idle();
      sweep_mem("odd_mem");

      // overflow: 32 full words, then one extra byte
      do_reset();
      for (int w = 0; w < 32; w++) begin
         send(8'(w + 8'h40), 0);
         send(8'(8'hC0 ^ w), 0);
      end
      chk("full_words", words_loaded, 32);
      chk("full_ready", load_ready, 1);
      send(8'h99, 0);
      chk("ovf_err", load_error, 1);
      chk("ovf_words", words_loaded, 32);
      read_at("ovf_mem31", 31, {8'(31 + 8'h40), 8'(8'hC0 ^ 31)});
      sweep_mem("ovf_mem");

      // reset mid-word, then a fresh 2-byte load
      do_reset();
      send(8'h12, 0); send(8'h34, 0); send(8'h56, 0);
      load_valid = 1; load_byte = 8'h78; load_last = 1;
      reset = 1;
      cyc();
      reset = 0;
      idle();
      cyc();
      chk("mid_ready", load_ready, 1);
      chk("mid_words", words_loaded, 0);
      sweep_mem("mid_mem");
      send(8'hCA, 0); send(8'hFE, 1);
      chk("fresh_start", start_execution, 1);
      chk("fresh_words", words_loaded, 1);
      read_at("fresh_mem0", 0, 16'hCAFE);

      // random streams with gaps and core writes during load
      for (int it = 0; it < 24; it++) begin
         int len;
         int last_at;
         do_reset();
         len = $urandom_range(1, 70);
         last_at = ($urandom_range(0, 3) == 0) ? -1 : len - 1;
         if ($urandom_range(0, 4) == 0) last_at = $urandom_range(0, len - 1);
         for (int k = 0; k < len; k++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
               load_valid = 0;
               load_byte = 8'($urandom);
               load_last = 1'($urandom);
               core_addr = 5'($urandom);
               core_write = 1'($urandom);
               core_write_data = 16'($urandom);
               cyc();
            end
            load_valid = 1;
            load_byte = 8'($urandom);
            load_last = (k == last_at);
            core_addr = 5'($urandom);
            core_write = 1'($urandom);
            core_write_data = 16'($urandom);
            cyc();
         end
         load_valid = 0; load_last = 0;
         for (int c = 0; c < 30; c++) begin
            load_valid = 1'($urandom);
            load_byte = 8'($urandom);
            core_addr = 5'($urandom);
            core_write = 1'($urandom);
            core_write_data = 16'($urandom);
            core_halted = ($urandom_range(0, 9) == 0);
            cyc();
         end
         sweep_mem("rand_mem");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: memory word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: address width in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 32: number of memory words.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port load_valid  input  1  a load byte is offered.
REQ-007 SHALL have port load_ready  output  1  loader can accept a byte.
REQ-008 SHALL have port load_byte  input  8  program byte, high byte of each word first.
REQ-009 SHALL have port load_last  input  1  marks the final byte of the program.
REQ-010 SHALL have port core_addr  input  ADDR_WIDTH  core memory address.
REQ-011 SHALL have port core_write  input  1  core write enable.
REQ-012 SHALL have port core_write_data  input  DATA_WIDTH  core write data.
REQ-013 SHALL have port core_read_data  output  DATA_WIDTH  memory word at core_addr.
REQ-014 SHALL have port core_halted  input  1  core has executed HALT.
REQ-015 SHALL have port start_execution  output  1  core may run.
REQ-016 SHALL have port words_loaded  output  ADDR_WIDTH+1  count of words written by the loader.
REQ-017 SHALL have port done  output  1  the program has finished.
REQ-018 SHALL have port load_error  output  1  malformed or oversized program.

Function
REQ-019 SHALL contain a MEM_DEPTH x DATA_WIDTH memory with synchronous write and combinational read: core_read_data = mem[core_addr] in every state, with zero-cycle latency.
REQ-020 SHALL implement states LOAD_HI, LOAD_LO, RUN, DONE and ERROR.
REQ-021 SHALL drive load_ready high in LOAD_HI and LOAD_LO and low in all other states.
REQ-022 SHALL accept a byte only on a cycle where load_valid and load_ready are both high; load_byte and load_last are ignored otherwise.
REQ-023 SHALL, in LOAD_HI with wr_ptr < MEM_DEPTH, accept a byte with load_last=0 as follows: latch it as the high byte and go to LOAD_LO.
REQ-024 SHALL, in LOAD_HI, go to ERROR if the accepted byte has load_last=1 (odd byte count).
REQ-025 SHALL, in LOAD_HI with wr_ptr == MEM_DEPTH, go to ERROR on any accepted byte (overflow); the memory is not written.
REQ-026 SHALL, in LOAD_LO, write {high byte, accepted byte} to mem[wr_ptr] on the accepting edge, increment wr_ptr, then go to RUN if load_last=1, otherwise to LOAD_HI.
REQ-027 SHALL make a loaded word readable on core_read_data the cycle after its low byte is accepted.
REQ-028 SHALL drive start_execution as a registered output that is high exactly while in RUN, first high the cycle after the final byte is accepted.
REQ-029 SHALL, in RUN and DONE, write core_write_data to mem[core_addr] on the edge where core_write=1.
REQ-030 SHALL ignore core_write in LOAD_HI, LOAD_LO and ERROR.
REQ-031 SHALL go from RUN to DONE on the edge where core_halted=1 is sampled; start_execution is low from the next cycle.
REQ-032 SHALL hold DONE and ERROR until reset.
REQ-033 SHALL drive done high exactly while in DONE.
REQ-034 SHALL drive load_error high exactly while in ERROR.
REQ-035 SHALL drive words_loaded = wr_ptr (0..MEM_DEPTH), which is unchanged after the load phase.
REQ-036 SHALL ignore load_valid in RUN, DONE and ERROR; no memory or counter change results.

Reset
REQ-037 SHALL, on reset, enter LOAD_HI and clear wr_ptr and the latched high byte.
REQ-038 SHALL, on reset, clear every memory word to 0.
REQ-039 SHALL, on reset, drive load_ready=1, start_execution=0, done=0, load_error=0 and words_loaded=0 from the next cycle.
REQ-040 SHALL take reset over all other inputs, in any state including mid-word and RUN.

Verification
REQ-041 Load bytes 0x88,0x05,0xF8,0x00 (last on the 4th) -> mem[0]=0x8805, mem[1]=0xF800; start_execution=1 one cycle after the 4th byte; words_loaded=2.
REQ-042 In RUN, core_addr=3, core_write=1, data 0xBEEF, then core_halted=1 -> mem[3]=0xBEEF; next cycle start_execution=0 and done=1.
REQ-043 Send a single byte with load_last=1 -> load_error=1 and load_ready=0; words_loaded=0; further load_valid has no effect.
REQ-044 Load 32 words without load_last, then one more byte -> load_error=1; words_loaded=32; mem[31] holds the 32nd word.
REQ-045 Assert reset after 3 bytes -> all memory reads 0; words_loaded=0; load_ready=1; a fresh 2-byte load succeeds.
REQ-046 Hold load_valid low for random gaps between bytes, and drive core_write=1 during load -> memory matches the byte stream only; the core write is not applied.
